// File: rtl/vga_fetch_pkg.sv
// Shared constants for the display prefetch path.
// Holds the frame geometry and the arbiter read-queue length that the fetch
// stage defaults to, plus the default pixel width and prefetch depth.
package vga_fetch_pkg;

  // Displayed frame geometry.
  localparam int unsigned IMAGE_WIDTH        = 640;
  localparam int unsigned IMAGE_HEIGHT       = 480;

  // Arbiter read queue length; a read returns this many cycles after accept.
  localparam int unsigned ARB_READ_QUEUE_LEN = 3;

  // Default arbiter pixel width and prefetch buffer depth.
  localparam int unsigned DEF_PIXEL_WIDTH    = 24;
  localparam int unsigned DEF_FIFO_DEPTH     = 8;

endpackage

// File: rtl/vga_fetch_sync_fifo.sv
// Synchronous FIFO with registered pop data and a synchronous clear.
// Ports:
//   clock, reset         : clock, async active-high reset
//   clear_i              : drop all contents on the next edge
//   push_i / wdata_i     : write one entry
//   pop_i                : read one entry; data appears on rdata_o next cycle
//   rdata_o              : popped data, 0 in cycles after no pop
//   count_o              : current occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Storage array; no reset needed, occupancy tracking guards reads.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer/occupancy update; a pop coincident with clear still returns old data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = pop_i ? mem_q[rd_ptr_q] : '0;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;

  // The producer throttles itself, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push_i && !pop_i && (count_q == CW'(DEPTH))));
  a_no_underrun: assert property (@(posedge clock) disable iff (reset)
    !(pop_i && (count_q == '0)));

endmodule

// File: rtl/vga_fetch.sv
// Display-side pixel prefetch between the SRAM arbiter and VGA timing.
// Issues sequential reads via vga_flag/done_vga, tracks the fixed read
// latency with a valid shift register, buffers returns in a FIFO and hands
// one pixel per pixel_req back with one cycle of latency.
// Ports:
//   clock, reset   : clock, async active-high reset
//   frame_flag     : start-of-frame pulse, flushes and restarts fetching
//   pixel_req      : display consumes one pixel this cycle
//   vga_flag       : read request to the arbiter (combinational)
//   done_vga       : arbiter accepted the request this cycle
//   vga_pixel      : read data returning from the arbiter
//   pix_out        : pixel to the display (registered)
//   pix_valid      : pix_out carries FIFO data (registered)
//   underflow      : sticky, pixel_req seen with an empty FIFO this frame
module vga_fetch
  import vga_fetch_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned READ_LATENCY = ARB_READ_QUEUE_LEN,
  parameter int unsigned FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_flag,
  input  logic                   pixel_req,
  output logic                   vga_flag,
  input  logic                   done_vga,
  input  logic [PIXEL_WIDTH-1:0] vga_pixel,
  output logic [PIXEL_WIDTH-1:0] pix_out,
  output logic                   pix_valid,
  output logic                   underflow
);

  localparam int unsigned RCW = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW  = CW + 1;

  logic [RCW-1:0]          req_cnt_q, req_cnt_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [READ_LATENCY-1:0] ret_q, ret_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    underflow_q, underflow_d;
  logic [CW-1:0]           count;
  logic [SW-1:0]           level;
  logic                    flushing, accept, push, pop;

  // No request while reset or a frame restart is in progress.
  assign flushing = frame_flag | reset;
  // Buffered plus outstanding reads; one bit wider so the sum cannot wrap.
  assign level    = SW'(count) + SW'(inflight_q);
  assign vga_flag = !flushing && (req_cnt_q < RCW'(FRAME_PIXELS))
                    && (level < SW'(FIFO_DEPTH));
  assign accept   = vga_flag & done_vga;
  assign push     = ret_q[READ_LATENCY-1];
  assign pop      = pixel_req & (count != '0);

  // Counters, return tracking and status; frame_flag overrides everything.
  always_comb begin
    req_cnt_d   = req_cnt_q;
    inflight_d  = inflight_q;
    ret_d       = (ret_q << 1) | READ_LATENCY'(accept);
    pix_valid_d = pop;
    underflow_d = underflow_q;
    if (accept) req_cnt_d = req_cnt_q + RCW'(1);
    case ({accept, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (pixel_req && (count == '0)) underflow_d = 1'b1;
    if (frame_flag) begin
      req_cnt_d   = '0;
      inflight_d  = '0;
      ret_d       = '0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_cnt_q   <= '0;
      inflight_q  <= '0;
      ret_q       <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      inflight_q  <= inflight_d;
      ret_q       <= ret_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // Prefetch buffer; its registered pop data is the display pixel.
  sync_fifo #(
    .WIDTH (PIXEL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear_i (frame_flag),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (vga_pixel),
    .rdata_o (pix_out),
    .count_o (count)
  );

  assign pix_valid = pix_valid_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fetch.sv
// Testbench for vga_fetch: arbiter model returning the frame address as data
// three cycles after accept, plus a queue-based reference of the fetch stage.
module tb_vga_fetch;

  localparam int unsigned PW    = 24;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned FP    = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_flag, pixel_req, done_vga;
  logic          vga_flag;
  logic [PW-1:0] vga_pixel, pix_out;
  logic          pix_valid, underflow;

  int checks = 0;
  int fails  = 0;

  vga_fetch #(
    .PIXEL_WIDTH  (PW),
    .FIFO_DEPTH   (DEPTH),
    .READ_LATENCY (LAT),
    .FRAME_PIXELS (FP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_flag (frame_flag),
    .pixel_req  (pixel_req),
    .vga_flag   (vga_flag),
    .done_vga   (done_vga),
    .vga_pixel  (vga_pixel),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .underflow  (underflow)
  );

  always #5 clock = ~clock;

  // Arbiter model: returns the per-frame read address LAT cycles after accept,
  // random junk on cycles with nothing returning.
  logic [PW-1:0] arb_addr, p0, p1, p2;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      arb_addr <= '0; p0 <= '0; p1 <= '0; p2 <= '0;
    end else begin
      p1 <= p0;
      p2 <= p1;
      if (vga_flag && done_vga) begin
        p0       <= arb_addr;
        arb_addr <= arb_addr + 1'b1;
      end else begin
        p0 <= PW'($urandom);
      end
      if (frame_flag) arb_addr <= '0;
    end
  end
  assign vga_pixel = p2;

  // Reference model state: FIFO contents and outstanding reads (due cycle, data).
  logic [PW-1:0] m_fifo[$];
  int            m_due[$];
  logic [PW-1:0] m_dat[$];
  int            m_req, m_cyc;
  bit            m_under;

  bit            exp_flag, exp_valid;
  logic [PW-1:0] exp_pix;
  logic          obs_flag, obs_valid, obs_under;
  logic [PW-1:0] obs_pix;

  task automatic model_clear();
    m_fifo.delete(); m_due.delete(); m_dat.delete();
    m_req = 0; m_under = 1'b0;
  endtask

  // Drive one cycle, advance the model, and sample the DUT for the caller.
  task automatic step(input bit ff, input bit pr, input bit dv);
    int lvl;
    frame_flag = ff; pixel_req = pr; done_vga = dv;
    #1;
    lvl      = m_fifo.size() + m_due.size();
    exp_flag = !ff && (m_req < int'(FP)) && (lvl < int'(DEPTH));
    obs_flag = vga_flag;
    if (pr && m_fifo.size() > 0) begin
      exp_pix = m_fifo.pop_front(); exp_valid = 1'b1;
    end else begin
      exp_pix = '0; exp_valid = 1'b0;
      if (pr) m_under = 1'b1;
    end
    if (m_due.size() > 0 && m_due[0] == m_cyc) begin
      void'(m_due.pop_front());
      m_fifo.push_back(m_dat.pop_front());
    end
    if (exp_flag && dv) begin
      m_due.push_back(m_cyc + int'(LAT));
      m_dat.push_back(PW'(m_req));
      m_req++;
    end
    if (ff) model_clear();
    m_cyc++;
    @(posedge clock); #1;
    obs_pix = pix_out; obs_valid = pix_valid; obs_under = underflow;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_flag = 1'b0; pixel_req = 1'b0; done_vga = 1'b0;
    model_clear(); m_cyc = 0;
    repeat (2) @(posedge clock);
    #1;
    if (vga_flag !== 1'b0) begin fails++; $display("FAIL reset vga_flag got=%b exp=0", vga_flag); end
    checks++;
    if (pix_out !== '0) begin fails++; $display("FAIL reset pix_out got=%0h exp=0", pix_out); end
    checks++;
    if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset pix_valid got=%b exp=0", pix_valid); end
    checks++;
    if (underflow !== 1'b0) begin fails++; $display("FAIL reset underflow got=%b exp=0", underflow); end
    checks++;
    reset = 1'b0;
  endtask

  // done_vga held high, no pops: eight accepts then throttle.
  task automatic test_fill();
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (obs_flag !== exp_flag) begin fails++; $display("FAIL fill vga_flag cyc=%0d got=%b exp=%b", i, obs_flag, exp_flag); end
      checks++;
    end
    if (arb_addr !== PW'(8)) begin fails++; $display("FAIL fill accepts got=%0d exp=8", arb_addr); end
    checks++;
  endtask

  // Continuous pops from cycle 12 stream a full frame, then one extra pop.
  task automatic test_stream();
    for (int i = 0; i <= int'(FP); i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (obs_flag !== exp_flag) begin fails++; $display("FAIL stream vga_flag i=%0d got=%b exp=%b", i, obs_flag, exp_flag); end
      checks++;
      if (obs_pix !== exp_pix || obs_valid !== exp_valid) begin
        fails++; $display("FAIL stream pix i=%0d got=%0h/%b exp=%0h/%b", i, obs_pix, obs_valid, exp_pix, exp_valid);
      end
      checks++;
      if (obs_under !== m_under) begin fails++; $display("FAIL stream underflow i=%0d got=%b exp=%b", i, obs_under, m_under); end
      checks++;
    end
    if (arb_addr !== PW'(FP)) begin fails++; $display("FAIL stream accepts got=%0d exp=%0d", arb_addr, FP); end
    checks++;
    if (obs_pix !== '0 || obs_valid !== 1'b0 || obs_under !== 1'b1) begin
      fails++; $display("FAIL stream extra_pop got=%0h/%b/%b exp=0/0/1", obs_pix, obs_valid, obs_under);
    end
    checks++;
  endtask

  // Alternating done_vga with a pop every cycle drains the buffer.
  task automatic test_underflow();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, i[0] == 1'b0);
      if (obs_pix !== exp_pix || obs_valid !== exp_valid) begin
        fails++; $display("FAIL underflow pix i=%0d got=%0h/%b exp=%0h/%b", i, obs_pix, obs_valid, exp_pix, exp_valid);
      end
      checks++;
      if (obs_under !== m_under) begin fails++; $display("FAIL underflow flag i=%0d got=%b exp=%b", i, obs_under, m_under); end
      checks++;
    end
    step(1'b1, 1'b0, 1'b0);
    if (obs_under !== 1'b0) begin fails++; $display("FAIL underflow clear got=%b exp=0", obs_under); end
    checks++;
  endtask

  // Frame restart with three reads outstanding: their returns must be lost.
  task automatic test_flush();
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    if (obs_flag !== 1'b0) begin fails++; $display("FAIL flush vga_flag got=%b exp=0", obs_flag); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (obs_flag !== exp_flag) begin fails++; $display("FAIL flush refill i=%0d got=%b exp=%b", i, obs_flag, exp_flag); end
      checks++;
    end
    step(1'b0, 1'b1, 1'b1);
    if (obs_pix !== '0 || obs_valid !== 1'b1) begin
      fails++; $display("FAIL flush first_pix got=%0h/%b exp=0/1", obs_pix, obs_valid);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (obs_pix !== exp_pix || obs_valid !== exp_valid) begin
        fails++; $display("FAIL flush pix i=%0d got=%0h/%b exp=%0h/%b", i, obs_pix, obs_valid, exp_pix, exp_valid);
      end
      checks++;
    end
  endtask

  // Random handshake, pops and frame restarts against the reference model.
  task automatic test_random();
    bit ff, pr, dv;
    for (int i = 0; i < 400; i++) begin
      ff = ($urandom_range(0, 99) < 3);
      pr = ($urandom_range(0, 99) < 60);
      dv = ($urandom_range(0, 99) < 70);
      step(ff, pr, dv);
      if (obs_flag !== exp_flag) begin fails++; $display("FAIL random vga_flag i=%0d got=%b exp=%b", i, obs_flag, exp_flag); end
      checks++;
      if (obs_pix !== exp_pix || obs_valid !== exp_valid) begin
        fails++; $display("FAIL random pix i=%0d got=%0h/%b exp=%0h/%b", i, obs_pix, obs_valid, exp_pix, exp_valid);
      end
      checks++;
      if (obs_under !== m_under) begin fails++; $display("FAIL random underflow i=%0d got=%b exp=%b", i, obs_under, m_under); end
      checks++;
    end
  endtask

  // Async reset mid-cycle with five entries buffered and a pixel on the output.
  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    if (obs_pix !== PW'(1) || obs_valid !== 1'b1) begin
      fails++; $display("FAIL areset pre_pix got=%0h/%b exp=1/1", obs_pix, obs_valid);
    end
    checks++;
    frame_flag = 1'b0; pixel_req = 1'b0; done_vga = 1'b1;
    #2 reset = 1'b1;
    #1;
    if (vga_flag !== 1'b0 || pix_out !== '0 || pix_valid !== 1'b0 || underflow !== 1'b0) begin
      fails++; $display("FAIL areset outputs got=%b/%0h/%b/%b exp=0/0/0/0", vga_flag, pix_out, pix_valid, underflow);
    end
    checks++;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    repeat (4) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (obs_pix !== exp_pix || obs_valid !== exp_valid) begin
        fails++; $display("FAIL areset pix i=%0d got=%0h/%b exp=%0h/%b", i, obs_pix, obs_valid, exp_pix, exp_valid);
      end
      checks++;
      if (i == 0 && (obs_pix !== '0 || obs_valid !== 1'b1)) begin
        fails++; $display("FAIL areset first_pix got=%0h/%b exp=0/1", obs_pix, obs_valid);
      end
      if (i == 0) checks++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_underflow();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_fetch.md
# vga_fetch

Display-side prefetch stage between the SRAM arbiter and the VGA output timing. Issues sequential pixel reads for the displayed frame through the arbiter's `vga_flag`/`done_vga` handshake. Absorbs the fixed read-return latency in a small FIFO, and delivers one pixel per `pixel_req` with fixed one-cycle latency. Restarts at every `frame_flag` and reports underflow.

## Interface

Parameters:
- `PIXEL_WIDTH`, 24: width of a returned display pixel, equal to arbiter `vga_pixel` width.
- `FIFO_DEPTH`, 8: prefetch buffer entries; power of two, at least `READ_LATENCY+2`.
- `READ_LATENCY`, 3: cycles from accepted request to data on `vga_pixel`; equals the arbiter read-queue length.
- `FRAME_PIXELS`, `IMAGE_WIDTH*IMAGE_HEIGHT`: reads per frame.

Ports:
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `frame_flag` in 1: 1-cycle start-of-frame pulse; restarts fetching.
- `pixel_req` in 1: display consumes one pixel this cycle (active region only).
- `vga_flag` out 1: read request to arbiter.
- `done_vga` in 1: arbiter accepted the request this cycle.
- `vga_pixel` in `PIXEL_WIDTH`: read data from arbiter.
- `pix_out` out `PIXEL_WIDTH`: pixel to display.
- `pix_valid` out 1: `pix_out` carries FIFO data this cycle.
- `underflow` out 1: sticky; set on a `pixel_req` with empty FIFO, cleared by `frame_flag`.

## Operation

- Request counter `req_cnt` (0..`FRAME_PIXELS`) counts accepted reads this frame.
- `inflight` counts accepted but not yet returned reads.
- `count` is current FIFO occupancy.
- `vga_flag` = `!flushing && req_cnt < FRAME_PIXELS && (count + inflight) < FIFO_DEPTH`. It is combinational from registers only, with no dependence on `done_vga`.
- Accept = `vga_flag && done_vga`. On accept: `req_cnt`+1 and `inflight`+1.
- Return tracking is a `READ_LATENCY`-deep valid shift register. Accept enters at stage 0. When the last stage is 1, `vga_pixel` is pushed to the FIFO and `inflight`-1.
- Pop on `pixel_req` with `count>0`. Push and pop in the same cycle are legal in all occupancy states. The throttle guarantees push never hits a full FIFO. Overflow is an assertion failure, not handled.
- `pixel_req` with empty FIFO gives `pix_out`=0, `pix_valid`=0, and sets `underflow`.
- Any `pixel_req` after `FRAME_PIXELS` pops gives 0 and `underflow`.
- `frame_flag` clears FIFO pointers, `count`, `req_cnt`, `inflight`, the valid shift register and `underflow` on the next edge. Returns still in flight at that edge are dropped, because the shift register is cleared. No `vga_flag` is raised in the `frame_flag` cycle.
- If `frame_flag` and an accept coincide, the accept is discarded (counters clear).
- If `frame_flag` and `pixel_req` coincide, the pop is served from pre-flush contents.

## Timing

- Reset values: `vga_flag`=0, `pix_out`=0, `pix_valid`=0, `underflow`=0. All counters, pointers and the shift register are 0.
- Reset asserted mid-frame behaves like `frame_flag`, but is immediate and asynchronous.
- First `vga_flag` is the cycle after reset/`frame_flag` deasserts.
- Data accepted at cycle N is pushed at edge N+`READ_LATENCY`. It can be popped by a `pixel_req` in cycle N+`READ_LATENCY`+1.
- `pix_out`/`pix_valid` are registered, valid the cycle after `pixel_req`, and held at 0/0 otherwise.
- Steady state: one accept per cycle until `count+inflight`=`FIFO_DEPTH`. Sustains one pixel per cycle when `done_vga` is held high.
- Widths: `req_cnt` is `$clog2(FRAME_PIXELS+1)`. `count`/`inflight` are `$clog2(FIFO_DEPTH+1)`; their sum is computed one bit wider.

## Structure

- `IMAGE_WIDTH`, `IMAGE_HEIGHT` and the arbiter read-queue length come from shared `params.v`. `READ_LATENCY` defaults to that constant.
- One sub-module: `sync_fifo` (parameterised width/depth, push/pop/count, pop-data registered, synchronous clear input driven by `frame_flag`).
- Throttle, counters and the latency shift register live in `vga_fetch`.

## Test plan

- Reset then `done_vga`=1 constantly, no `pixel_req` → exactly 8 accepts in cycles 1–8, `vga_flag`=0 from cycle 9; FIFO holds 8 after cycle 11.
- Model arbiter returning address as data, latency 3; `pixel_req` held from cycle 12 → `pix_out` = 0,1,2,… with no gaps and `underflow`=0 across a full frame.
- `done_vga` toggling 1/0 with `pixel_req` every cycle → `underflow` sets on the first empty pop, `pix_out`=0 there, and stays 1 until next `frame_flag`.
- `frame_flag` pulsed while `inflight`=3 → the 3 late returns are not pushed; next frame's first `pix_out` = 0 (address 0).
- `FRAME_PIXELS`=16 → exactly 16 accepts, then `vga_flag` stays 0; the 17th `pixel_req` gives 0 and `underflow`=1.
- Async `reset` asserted mid-cycle with FIFO at 5 → all outputs 0 immediately, fetch restarts at address 0 after release.
